// File: rtl/stopwatch_tick_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_tick_ctrl_pkg
// Purpose  : Shared definitions for the stopwatch control stage: the FSM state
//            encoding and the clock-divider ratio computation.
// Ports    : none (package)
// Config   : LAP_HOLD_EN is consumed by stopwatch_tick_ctrl, not here.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_tick_ctrl_pkg;

  // The encoding is visible on the state port, so it is fixed explicitly.
  // 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Number of clk cycles between increase pulses while running.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Synchronises one raw push-button and accepts a level change only
//            after it has been stable for DEB_CYCLES consecutive cycles.
//            Emits a one-cycle press pulse on an accepted rising level.
// Ports    : clk    in  1  clock, rising edge
//            rst    in  1  synchronous active-high reset
//            raw    in  1  asynchronous button level, high = pressed
//            stable out  1  debounced level
//            press  out  1  one-cycle pulse on accepted press
// Params   : DEB_CYCLES (>= 2)
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
  import stopwatch_tick_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 400_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int            CW      = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      // Any cycle agreeing with the accepted level restarts the qualification,
      // so only an uninterrupted run of disagreeing samples is accepted.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Rising edge of the accepted level only; a release produces no event.
  assign press = stable & ~stable_d;

endmodule
`default_nettype wire

// File: rtl/stopwatch_tick_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_tick_ctrl
// Purpose  : Control stage ahead of the stopwatch digit counters. Debounces
//            the start and clear buttons, runs the IDLE/RUN/PAUSE machine and
//            divides clk down to a one-cycle increase tick.
// Ports    : clk        in  1  clock, rising edge
//            rst        in  1  synchronous active-high reset
//            btn_start  in  1  raw start/pause button, high = pressed
//            btn_clear  in  1  raw clear/lap button, high = pressed
//            increase   out 1  registered one-cycle tick to the counter chain
//            clr        out 1  registered one-cycle clear to the counter chain
//            running    out 1  high while in RUN
//            state      out 2  IDLE=00, RUN=01, PAUSE=10
//            hold       out 1  lap-freeze request to the display
// Params   : CLK_HZ, TICK_HZ (CLK_HZ/TICK_HZ >= 2), DEB_CYCLES (>= 2)
// Config   : LAP_HOLD_EN - when defined, clear in RUN toggles hold;
//            when undefined, hold is tied low and clear in RUN is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_tick_ctrl
  import stopwatch_tick_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 40_000_000,
  parameter int TICK_HZ    = 100,
  parameter int DEB_CYCLES = 400_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic       increase,
  output logic       clr,
  output logic       running,
  output logic [1:0] state,
  output logic       hold
);

  localparam int            DIV       = calc_div(CLK_HZ, TICK_HZ);
  localparam int            PW        = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic start_press;
  logic clear_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_start),
    .stable (),
    .press  (start_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_clear),
    .stable (),
    .press  (clear_press)
  );

  state_t        state_q;
  state_t        state_n;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_n;
  logic          increase_n;
  logic          clr_n;

`ifdef LAP_HOLD_EN
  logic hold_q;
  logic hold_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      increase <= 1'b0;
      clr      <= 1'b0;
`ifdef LAP_HOLD_EN
      hold_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      presc_q  <= presc_n;
      increase <= increase_n;
      clr      <= clr_n;
`ifdef LAP_HOLD_EN
      hold_q   <= hold_n;
`endif
    end
  end

  always_comb begin
    state_n    = state_q;
    presc_n    = presc_q;
    increase_n = 1'b0;
    clr_n      = 1'b0;
`ifdef LAP_HOLD_EN
    hold_n     = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef LAP_HOLD_EN
        hold_n = 1'b0;
`endif
        // Start has priority; a simultaneous clear is dropped.
        if (start_press) begin
          state_n = ST_RUN;
          presc_n = '0;
        end else if (clear_press) begin
          clr_n = 1'b1;
        end
      end
      ST_RUN: begin
        if (start_press) begin
          // Prescaler phase is frozen on the pausing edge so that a resume
          // continues exactly where counting stopped.
          state_n = ST_PAUSE;
        end else begin
          if (presc_q == PRESC_MAX) begin
            presc_n    = '0;
            increase_n = 1'b1;
          end else begin
            presc_n = presc_q + PW'(1);
          end
`ifdef LAP_HOLD_EN
          if (clear_press) begin
            hold_n = ~hold_q;
          end
`endif
        end
      end
      ST_PAUSE: begin
        // Clear has priority here; a simultaneous start is dropped.
        if (clear_press) begin
          state_n = ST_IDLE;
          clr_n   = 1'b1;
`ifdef LAP_HOLD_EN
          hold_n  = 1'b0;
`endif
        end else if (start_press) begin
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_IDLE;
        presc_n = '0;
        clr_n   = 1'b1;
`ifdef LAP_HOLD_EN
        hold_n  = 1'b0;
`endif
      end
    endcase
  end

  assign state   = state_q;
  assign running = (state_q == ST_RUN);

`ifdef LAP_HOLD_EN
  assign hold = hold_q;
`else
  assign hold = 1'b0;
`endif

endmodule
`default_nettype wire
